conv2_psum_accum: RTL and testbench

Output-side accumulation stage for convolution layer 2. It consumes the 14-bit partial sum produced by one conv2 PE column (three stacked PE units) once per input channel. It accumulates `IN_CH` such psums per output pixel, adds a per-pixel bias, applies optional ReLU, then rounds, shifts and saturates the result to 8 bits. The 8-bit result is emitted over a valid/ready handshake to the ofmap writer.

---
 rtl/conv2_psum_accum.sv | 204 ++++++++++++++++++++
 tb/tb_conv2_psum_accum.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2_psum_accum.sv
// -----------------------------------------------------------------------------
// conv2_psum_accum
//
// Output-side accumulation stage for convolution layer 2. One conv2 PE column
// delivers a 14-bit signed partial sum per input channel. This block sums
// IN_CH of them per output pixel, adds a per-pixel bias, optionally applies
// ReLU, and then rounds, shifts and saturates the result to 8 bits. The 8-bit
// result is presented to the ofmap writer over a valid/ready handshake.
//
// Build option:
//   CONV2_PSUM_RELU_EN  defined   -> ReLU on, out_data unsigned, range [0, 255]
//                       undefined -> no ReLU, out_data signed, range [-128, 127]
//
// Parameters:
//   IN_CH  psums (input channels) per output pixel, >= 1
//   ACC_W  accumulator width, >= 14 + clog2(IN_CH) + 1
//   SHIFT  requantization right shift, >= 1
//
// Ports:
//   clk         PE clock, single clock domain
//   rst         synchronous active-high reset
//   psum_in     signed psum from the PE column
//   psum_valid  psum_in is valid
//   psum_ready  block accepts a psum this cycle (pure state decode)
//   bias_in     signed bias at accumulator scale, sampled on a pixel's 1st beat
//   out_data    quantized 8-bit result
//   out_valid   out_data is valid
//   out_ready   consumer accepts out_data
//   busy        high whenever a pixel is partially accumulated or in flight
// -----------------------------------------------------------------------------
module conv2_psum_accum #(
  parameter int IN_CH = 4,
  parameter int ACC_W = 20,
  parameter int SHIFT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [13:0] psum_in,
  input  logic               psum_valid,
  output logic               psum_ready,
  input  logic signed [15:0] bias_in,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  // ---------------------------------------------------------------------------
  // Derived sizes and constants
  // ---------------------------------------------------------------------------
  localparam int CNT_W = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  // acc + bias needs one extra bit; the rounding add gets one more so that
  // adding the half-LSB can never overflow the sum.
  localparam int SUM_W = ACC_W + 1;
  localparam int RND_W = ACC_W + 2;

  localparam logic [CNT_W-1:0]        LAST_CNT   = CNT_W'(IN_CH - 1);
  localparam logic signed [RND_W-1:0] ROUND_HALF = RND_W'(2 ** (SHIFT - 1));

`ifdef CONV2_PSUM_RELU_EN
  localparam logic signed [RND_W-1:0] SAT_HI = RND_W'(255);
`else
  localparam logic signed [RND_W-1:0] SAT_HI = RND_W'(127);
  localparam logic signed [RND_W-1:0] SAT_LO = -RND_W'(128);
`endif

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (IN_CH < 1) begin : g_bad_in_ch
    $error("conv2_psum_accum: IN_CH must be at least 1");
  end
  if (ACC_W < 14 + $clog2(IN_CH) + 1) begin : g_bad_acc_w
    $error("conv2_psum_accum: ACC_W too small for IN_CH psums of 14 bits");
  end
  if (SHIFT < 1) begin : g_bad_shift
    $error("conv2_psum_accum: SHIFT must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_POST  = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  state_e                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [15:0]      r_bias;
  logic [7:0]              r_out_data;
  logic                    r_out_valid;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic                    w_beat;
  logic signed [ACC_W-1:0] w_psum_ext;
  logic signed [SUM_W-1:0] w_sum;
  logic signed [SUM_W-1:0] w_sum_act;
  logic signed [RND_W-1:0] w_rnd_add;
  logic signed [RND_W-1:0] w_rnd;
  logic [7:0]              w_sat;

  // psum_ready comes only from the state register, so a beat never depends
  // combinationally on the downstream out_ready.
  assign psum_ready = (r_state == ST_ACCUM);
  assign busy       = (r_state != ST_ACCUM) || (r_cnt != '0);
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;

  assign w_beat     = psum_valid && psum_ready;

  // Signed casts to a wider size sign-extend.
  assign w_psum_ext = ACC_W'(psum_in);
  assign w_sum      = SUM_W'(r_acc) + SUM_W'(r_bias);

`ifdef CONV2_PSUM_RELU_EN
  assign w_sum_act  = w_sum[SUM_W-1] ? '0 : w_sum;
`else
  assign w_sum_act  = w_sum;
`endif

  // Round half up, then arithmetic shift (floor) to the output scale.
  assign w_rnd_add  = RND_W'(w_sum_act) + ROUND_HALF;
  assign w_rnd      = w_rnd_add >>> SHIFT;

  always_comb begin
    // NOTE: assign a default first so every path drives w_sat; a branch that
    // left it unassigned would infer a latch.
    w_sat = w_rnd[7:0];
`ifdef CONV2_PSUM_RELU_EN
    // ReLU already removed negatives, only the upper bound can be exceeded.
    if (w_rnd > SAT_HI) begin
      w_sat = 8'hFF;
    end
`else
    if (w_rnd > SAT_HI) begin
      w_sat = 8'h7F;
    end else if (w_rnd < SAT_LO) begin
      w_sat = 8'h80;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its inputs from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ACCUM;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_bias      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_beat) begin
            // The first beat of a pixel restarts the sum and captures the
            // bias, so nothing from the previous pixel can leak in.
            if (r_cnt == '0) begin
              r_acc  <= w_psum_ext;
              r_bias <= bias_in;
            end else begin
              r_acc  <= r_acc + w_psum_ext;
            end

            if (r_cnt == LAST_CNT) begin
              r_cnt   <= '0;
              r_state <= ST_POST;
            end else begin
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end
        end

        ST_POST: begin
          r_out_data  <= w_sat;
          r_out_valid <= 1'b1;
          r_state     <= ST_OUT;
        end

        ST_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_state     <= ST_ACCUM;
          end
        end

        default: begin
          r_state <= ST_ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv2_psum_accum.sv
// -----------------------------------------------------------------------------
// Self-checking bench for conv2_psum_accum (IN_CH=4, SHIFT=2).
// Directed scenarios with hand-derived results, then randomized pixels scored
// against an arithmetic reference model. A negedge monitor scores every output
// handshake and the OUT-state hold rules.
// -----------------------------------------------------------------------------
module tb_conv2_psum_accum;

  localparam int IN_CH = 4;
  localparam int ACC_W = 20;
  localparam int SHIFT = 2;

  typedef int pix_t [IN_CH];

  logic               clk = 1'b0;
  logic               rst;
  logic signed [13:0] psum_in;
  logic               psum_valid;
  logic               psum_ready;
  logic [15:0]        bias_in;
  logic [7:0]         out_data;
  logic               out_valid;
  bit                 out_ready;
  logic               busy;

  int          checks   = 0;
  int          failures = 0;
  int          ready_mode = 0;   // 0: low, 1: high, 2: random
  int          n_out = 0;
  logic [7:0]  exp_q [$];
  time         hs_times [$];
  bit          held = 1'b0;
  logic [7:0]  held_data;

  always #5 clk = ~clk;

  conv2_psum_accum #(
    .IN_CH (IN_CH),
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .psum_in    (psum_in),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .bias_in    (bias_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: sum everything, add bias, ReLU, round half up, floor divide
  // by 2^SHIFT, clamp to the output range.
  function automatic logic [7:0] model(input pix_t ps, input int b);
    longint s;
    s = b;
    for (int i = 0; i < IN_CH; i++) s += ps[i];
`ifdef CONV2_PSUM_RELU_EN
    if (s < 0) s = 0;
`endif
    s = (s + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
`ifdef CONV2_PSUM_RELU_EN
    if (s > 255) s = 255;
`else
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
`endif
    return 8'(s);
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!psum_ready && n < 200) begin
      step();
      n++;
    end
    check("psum_ready_wait", psum_ready, 1);
  endtask

  // Drives IN_CH beats; bias_in is scrambled on non-first beats so that only
  // the first-beat sample can produce the right answer.
  task automatic send_pixel(input pix_t ps, input int b, input bit gaps);
    for (int i = 0; i < IN_CH; i++) begin
      psum_in    = 14'(ps[i]);
      bias_in    = (i == 0) ? 16'(b) : 16'($urandom);
      psum_valid = 1'b1;
      wait_ready();
      step();
      psum_valid = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) step();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      step();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  function automatic int rnd_small(input int span);
    return int'($urandom_range(0, 2 * span)) - span;
  endfunction

  // ---------------------------------------------------------------------------
  // out_ready driver (sole writer of out_ready)
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (out_valid) check("ready_low_in_out", psum_ready, 0);
      if (held) begin
        check("out_valid_held", out_valid, 1);
        check("out_data_held", out_data, held_data);
      end
      if (out_valid && out_ready) begin
        check("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("out_data", out_data, exp_q.pop_front());
        hs_times.push_back($time);
        n_out++;
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    pix_t p;
    logic [7:0] e;
    int base_t, base_n, b;

    rst = 1'b1; psum_valid = 1'b0; psum_in = '0; bias_in = '0;
    repeat (3) step();
    rst = 1'b0;

    check("rst_psum_ready", psum_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);

    // Basic pixel with latency check: 264 -> (264+2)>>2 = 66.
    p = '{100, 200, -50, 10};
    exp_q.push_back(8'h42);
    send_pixel(p, 4, 1'b0);
    check("lat_post_valid", out_valid, 0);
    check("lat_post_ready", psum_ready, 0);
    check("lat_post_busy", busy, 1);
    step();
    check("lat_out_valid", out_valid, 1);
    ready_mode = 1;
    drain();

    // Negative: -400 -> 0 with ReLU, else -100.
    p = '{-100, -100, -100, -100};
`ifdef CONV2_PSUM_RELU_EN
    exp_q.push_back(8'h00);
`else
    exp_q.push_back(8'h9C);
`endif
    send_pixel(p, 0, 1'b0);
    drain();

    // Positive saturation: 32891 -> 8223.
    p = '{8191, 8191, 8191, 8191};
`ifdef CONV2_PSUM_RELU_EN
    exp_q.push_back(8'hFF);
`else
    exp_q.push_back(8'h7F);
`endif
    send_pixel(p, 127, 1'b0);
    drain();

    // Negative saturation: -65536 -> -16384.
    p = '{-8192, -8192, -8192, -8192};
`ifdef CONV2_PSUM_RELU_EN
    exp_q.push_back(8'h00);
`else
    exp_q.push_back(8'h80);
`endif
    send_pixel(p, -32768, 1'b0);
    drain();

    // Backpressure: hold out_ready low for 5 cycles with junk psum_valid.
    ready_mode = 0;
    p = '{150, -20, 33, 7};
    e = model(p, -9);
    exp_q.push_back(e);
    send_pixel(p, -9, 1'b0);
    step();
    check("bp_valid_rise", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      psum_valid = 1'b1;
      psum_in    = 14'($urandom);
      step();
      check("bp_ready_low", psum_ready, 0);
      check("bp_valid_hold", out_valid, 1);
      check("bp_data_hold", out_data, e);
    end
    psum_valid = 1'b0;
    ready_mode = 1;
    step();
    check("bp_ready_after_hs", psum_ready, 1);
    check("bp_queue_popped", exp_q.size(), 0);
    p = '{-7, 90, 12, 300};
    exp_q.push_back(model(p, 55));
    send_pixel(p, 55, 1'b0);
    drain();

    // Reset mid-pixel: two beats of 500 must be discarded.
    psum_in = 14'sd500; bias_in = 16'd1000; psum_valid = 1'b1;
    step();
    step();
    check("mid_busy", busy, 1);
    psum_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_ready", psum_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    p = '{1, 1, 1, 1};
    exp_q.push_back(8'h01);
    send_pixel(p, 0, 1'b0);
    drain();

    // Streaming: 3 back-to-back pixels at a 6-cycle period, fresh bias each.
    base_t = hs_times.size();
    base_n = n_out;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < IN_CH; i++) p[i] = rnd_small(200);
      b = rnd_small(400);
      exp_q.push_back(model(p, b));
      send_pixel(p, b, 1'b0);
    end
    drain();
    check("stream_count", n_out - base_n, 3);
    for (int i = 1; i < 3; i++)
      check("stream_period", 32'(hs_times[base_t + i] - hs_times[base_t + i - 1]), 60);

    // Randomized pixels, gaps on both sides.
    ready_mode = 2;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < IN_CH; i++) p[i] = int'($urandom_range(0, 16383)) - 8192;
        b = int'($urandom_range(0, 65535)) - 32768;
      end else begin
        for (int i = 0; i < IN_CH; i++) p[i] = rnd_small(300);
        b = rnd_small(500);
      end
      exp_q.push_back(model(p, b));
      send_pixel(p, b, 1'b1);
    end
    ready_mode = 1;
    drain();
    step();
    check("final_idle_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
